// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex display PIO: register map, hex segment table
// and blank-pattern helper.
package hex_display_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA   = 3'd0,
    ADDR_NIBBLE = 3'd1,
    ADDR_MODE   = 3'd2,
    ADDR_BLINK  = 3'd3,
    ADDR_OUTSET = 3'd4,
    ADDR_OUTCLR = 3'd5,
    ADDR_STATUS = 3'd6,
    ADDR_RSVD   = 3'd7
  } reg_addr_e;

  // Active-high g..a patterns, entry n at index n (F first in the literal).
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [7:0] blank_pattern(input logic active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex nibble to active-high seven-segment (g..a) decoder.
module hex7seg_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG_TABLE[nibble];
  end

endmodule

// File: rtl/hex_display_pio.sv
// Avalon-MM seven-segment display port: raw/decode per digit, blinking,
// atomic set/clear of raw bits, registered pin drive.
module hex_display_pio
  import hex_display_pkg::*;
#(
  parameter int unsigned               NUM_DIGITS = 2,
  parameter logic [8*NUM_DIGITS-1:0]   RESET_SEG  = 16'h6D79,
  parameter bit                        ACTIVE_LOW = 1'b1,
  parameter int unsigned               CLK_HZ     = 50_000_000,
  parameter int unsigned               BLINK_HZ   = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [2:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [8*NUM_DIGITS-1:0]   out_port
);

  localparam int unsigned W        = 8 * NUM_DIGITS;
  localparam int unsigned NW       = 4 * NUM_DIGITS;
  localparam int unsigned HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int unsigned CNT_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);
  localparam logic [7:0]       INV_MASK = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [W-1:0]          data;
  logic [NW-1:0]         nibble;
  logic [NUM_DIGITS-1:0] mode;
  logic [NUM_DIGITS-1:0] blink;
  logic [CNT_W-1:0]      cnt;
  logic                  phase;
  logic [W-1:0]          seg_next;
  logic [6:0]            dec [NUM_DIGITS];

  logic      wr_en;
  logic      blink_wr;
  reg_addr_e addr;
  logic      unused_wd;

  assign addr      = reg_addr_e'(address);
  assign wr_en     = chipselect && !write_n;
  assign blink_wr  = wr_en && (addr == ADDR_BLINK);
  assign unused_wd = ^writedata;

  // Register file; OUTSET/OUTCLR modify DATA in the same cycle they are written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data   <= RESET_SEG;
      nibble <= '0;
      mode   <= '0;
      blink  <= '0;
    end else if (wr_en) begin
      case (addr)
        ADDR_DATA:   data   <= writedata[W-1:0];
        ADDR_NIBBLE: nibble <= writedata[NW-1:0];
        ADDR_MODE:   mode   <= writedata[NUM_DIGITS-1:0];
        ADDR_BLINK:  blink  <= writedata[NUM_DIGITS-1:0];
        ADDR_OUTSET: data   <= data | writedata[W-1:0];
        ADDR_OUTCLR: data   <= data & ~writedata[W-1:0];
        default:     ;
      endcase
    end
  end

  // A BLINK write restarts the on-phase and takes priority over a terminal toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (blink_wr) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex7seg_decoder u_dec (
      .nibble (nibble[4*g +: 4]),
      .seg    (dec[g])
    );
  end

  always_comb begin
    seg_next = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (blink[i] && !phase) begin
        seg_next[8*i +: 8] = blank_pattern(ACTIVE_LOW);
      end else if (mode[i]) begin
        seg_next[8*i +: 8] = {data[8*i+7], dec[i]} ^ INV_MASK;
      end else begin
        seg_next[8*i +: 8] = data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_SEG;
    end else begin
      out_port <= seg_next;
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (addr)
        ADDR_DATA:   readdata[W-1:0]          = data;
        ADDR_NIBBLE: readdata[NW-1:0]         = nibble;
        ADDR_MODE:   readdata[NUM_DIGITS-1:0] = mode;
        ADDR_BLINK:  readdata[NUM_DIGITS-1:0] = blink;
        ADDR_STATUS: readdata[0]              = phase;
        default:     ;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_pio.sv
// Self-checking bench for hex_display_pio: directed scenarios plus random bus
// traffic checked against a cycle-level behavioural model.
module tb_hex_display_pio;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] out_port;

  int n_tests = 0;
  int n_fail  = 0;

  hex_display_pio #(
    .NUM_DIGITS (2),
    .RESET_SEG  (16'h6D79),
    .ACTIVE_LOW (1'b1),
    .CLK_HZ     (1000),
    .BLINK_HZ   (100)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: run did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0] m_data;
  logic [7:0]  m_nib;
  logic [1:0]  m_mode, m_blink;
  int          since;       // clock edges since reset or last BLINK write
  logic [15:0] exp_out;

  function automatic logic m_phase();
    return ((since / HALF) % 2) == 0;
  endfunction

  function automatic logic [15:0] render();
    logic [15:0] r;
    for (int i = 0; i < 2; i++) begin
      if (m_blink[i] && !m_phase())
        r[8*i +: 8] = 8'hFF;
      else if (m_mode[i])
        r[8*i +: 8] = ~{m_data[8*i+7], seg_tab[m_nib[4*i +: 4]]};
      else
        r[8*i +: 8] = m_data[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input logic cs, input logic [2:0] a);
    if (!cs) return 32'h0;
    case (a)
      3'd0: return {16'h0, m_data};
      3'd1: return {24'h0, m_nib};
      3'd2: return {30'h0, m_mode};
      3'd3: return {30'h0, m_blink};
      3'd6: return {31'h0, m_phase()};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = 16'h6D79; m_nib = '0; m_mode = '0; m_blink = '0;
      since = 0; exp_out = 16'h6D79;
    end else begin
      exp_out = render();
      since++;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data = writedata[15:0];
          3'd1: m_nib  = writedata[7:0];
          3'd2: m_mode = writedata[1:0];
          3'd3: begin m_blink = writedata[1:0]; since = 0; end
          3'd4: m_data = m_data | writedata[15:0];
          3'd5: m_data = m_data & ~writedata[15:0];
          default: ;
        endcase
      end
      #1;
      if (reset_n) check_eq("out_port_model", {16'h0, out_port}, {16'h0, exp_out});
    end
  end

  // ---------------- bus tasks (called at a negedge) ----------------
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // 1. reset values
    check_eq("reset_out", {16'h0, out_port}, 32'h6D79);
    rd(3'd0, v); check_eq("reset_data", v, 32'h6D79);
    rd(3'd6, v); check_eq("reset_status", v, 32'h1);
    @(negedge clk);

    // 2. set/clear back-to-back
    wr(3'd0, 32'h0000); wr(3'd4, 32'h8001); wr(3'd5, 32'h0001);
    rd(3'd0, v); check_eq("setclr_data", v, 32'h8000);
    @(negedge clk);
    check_eq("setclr_out", {16'h0, out_port}, 32'h8000);

    // 3. decode mode
    wr(3'd1, 32'hA3); wr(3'd2, 32'h3); wr(3'd0, 32'h0);
    @(negedge clk);
    check_eq("decode_out", {16'h0, out_port}, 32'h88B0);

    // 4. blink digit0
    wr(3'd0, 32'h1234); wr(3'd2, 32'h0); wr(3'd3, 32'h1);
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      check_eq("blink_out", {16'h0, out_port},
               {16'h0, 8'h12, (((j - 1) / HALF) % 2 == 0) ? 8'h34 : 8'hFF});
      rd(3'd6, v);
      check_eq("blink_status", v, ((j / HALF) % 2 == 0) ? 32'h1 : 32'h0);
    end

    // 5. BLINK write on the terminal cycle
    wr(3'd3, 32'h1);
    repeat (4) @(negedge clk);
    wr(3'd3, 32'h1);
    rd(3'd6, v); check_eq("term_status", v, 32'h1);
    repeat (4) @(negedge clk);
    rd(3'd6, v); check_eq("term_status_4", v, 32'h1);
    @(negedge clk);
    rd(3'd6, v); check_eq("term_status_5", v, 32'h0);
    check_eq("term_out_5", {16'h0, out_port}, 32'h1234);
    @(negedge clk);
    check_eq("term_out_6", {16'h0, out_port}, 32'h12FF);

    // 6. asynchronous reset mid-blink with decode active
    wr(3'd1, 32'h5C); wr(3'd2, 32'h3);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_eq("async_rst_out", {16'h0, out_port}, 32'h6D79);
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd0, v); check_eq("rst_data", v, 32'h6D79);
    rd(3'd1, v); check_eq("rst_nibble", v, 32'h0);
    rd(3'd2, v); check_eq("rst_mode", v, 32'h0);
    rd(3'd3, v); check_eq("rst_blink", v, 32'h0);
    rd(3'd6, v); check_eq("rst_status", v, 32'h1);
    @(negedge clk);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      int op;
      logic [2:0] a;
      op = $urandom_range(0, 9);
      a  = 3'($urandom_range(0, 7));
      if (op <= 3) begin
        wr(a, $urandom);
      end else if (op == 4) begin
        // write strobe without chipselect must be ignored
        chipselect = 1'b0; write_n = 1'b0; address = a; writedata = $urandom;
        @(negedge clk);
        write_n = 1'b1;
      end else if (op <= 7) begin
        rd(a, v); check_eq("rand_read", v, exp_read(1'b1, a));
        @(negedge clk);
      end else if (op == 8) begin
        address = a; chipselect = 1'b0;
        #1 check_eq("rand_read_nocs", readdata, exp_read(1'b0, a));
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
